// File: rtl/fast_packet_decode_module_if.sv
// Byte-stream input and decoded-message output bundle for the fast packet decoder.
// The master side drives encoded bytes; the slave side (the decoder) returns
// decoded messages, packet-complete pulses and protocol-error pulses.
interface fast_packet_decode_module_if #(
  parameter int MAX_ORIGINAL_DATA_BITS = 264
);
  logic [7:0]                        byte_in;
  logic                              byte_valid_in;
  logic                              msg_valid_out;
  logic [MAX_ORIGINAL_DATA_BITS-1:0] msg_data_out;
  logic [5:0]                        msg_len_out;
  logic [1:0]                        msg_idx_out;
  logic                              pkt_done_out;
  logic [1:0]                        msg_cnt_out;
  logic                              err_out;

  modport master (
    output byte_in, byte_valid_in,
    input  msg_valid_out, msg_data_out, msg_len_out, msg_idx_out,
           pkt_done_out, msg_cnt_out, err_out
  );

  modport slave (
    input  byte_in, byte_valid_in,
    output msg_valid_out, msg_data_out, msg_len_out, msg_idx_out,
           pkt_done_out, msg_cnt_out, err_out
  );
endinterface

// File: rtl/fast_packet_decode_module.sv
// Fast packet decoder: STX, up to MAX_MSGS stop-bit-length-prefixed messages, ETX.
// Each decoded message is presented left-aligned (first byte in the top bits)
// and zero-padded, together with its length and position in the packet.
module fast_packet_decode_module #(
  parameter int MAX_ORIGINAL_DATA_BITS = 264,
  parameter int MAX_MSGS               = 3
) (
  input logic                        clk,
  input logic                        rst_n,
  fast_packet_decode_module_if.slave bus
);
  localparam int         DW      = MAX_ORIGINAL_DATA_BITS;
  localparam int         MAX_LEN = MAX_ORIGINAL_DATA_BITS / 8;
  localparam logic [7:0] STX     = 8'h02;
  localparam logic [7:0] ETX     = 8'h03;

  typedef enum logic [1:0] {IDLE, LEN, BODY, NEXT} state_t;

  state_t         state, state_nxt;
  logic           len_seen, len_seen_nxt;
  logic [6:0]     len_acc, len_acc_nxt;
  logic [5:0]     body_cnt, body_cnt_nxt;
  logic [5:0]     msg_len, msg_len_nxt;
  logic [1:0]     msg_count, msg_count_nxt;
  logic [DW-1:0]  data_buf, data_buf_nxt;

  logic           msg_valid_q, msg_valid_nxt;
  logic [DW-1:0]  msg_data_q, msg_data_nxt;
  logic [5:0]     msg_len_q, msg_len_q_nxt;
  logic [1:0]     msg_idx_q, msg_idx_nxt;
  logic           pkt_done_q, pkt_done_nxt;
  logic [1:0]     msg_cnt_q, msg_cnt_nxt;
  logic           err_q, err_nxt;

  logic           len_step;
  logic           first_len;
  logic [13:0]    len_full;
  logic           len_ok;

  assign bus.msg_valid_out = msg_valid_q;
  assign bus.msg_data_out  = msg_data_q;
  assign bus.msg_len_out   = msg_len_q;
  assign bus.msg_idx_out   = msg_idx_q;
  assign bus.pkt_done_out  = pkt_done_q;
  assign bus.msg_cnt_out   = msg_cnt_q;
  assign bus.err_out       = err_q;

  // Next-state and next-output decode; pulses default low, held values default to current.
  always_comb begin
    state_nxt     = state;
    len_seen_nxt  = len_seen;
    len_acc_nxt   = len_acc;
    body_cnt_nxt  = body_cnt;
    msg_len_nxt   = msg_len;
    msg_count_nxt = msg_count;
    data_buf_nxt  = data_buf;
    msg_valid_nxt = 1'b0;
    msg_data_nxt  = msg_data_q;
    msg_len_q_nxt = msg_len_q;
    msg_idx_nxt   = msg_idx_q;
    pkt_done_nxt  = 1'b0;
    msg_cnt_nxt   = msg_cnt_q;
    err_nxt       = 1'b0;
    len_step      = 1'b0;

    // A byte arriving in NEXT always starts a fresh length field.
    first_len = (state == NEXT) || !len_seen;
    len_full  = first_len ? {7'd0, bus.byte_in[6:0]} : {len_acc, bus.byte_in[6:0]};
    len_ok    = (len_full >= 14'd1) && (len_full <= 14'(MAX_LEN));

    if (bus.byte_valid_in) begin
      case (state)
        IDLE: begin
          if (bus.byte_in == STX) begin
            state_nxt     = LEN;
            msg_count_nxt = 2'd0;
            len_seen_nxt  = 1'b0;
            len_acc_nxt   = 7'd0;
            data_buf_nxt  = '0;
          end
        end
        LEN: begin
          if (!len_seen && (msg_count == 2'd0) && (bus.byte_in == ETX)) begin
            pkt_done_nxt = 1'b1;
            msg_cnt_nxt  = 2'd0;
            state_nxt    = IDLE;
          end else begin
            len_step = 1'b1;
          end
        end
        BODY: begin
          data_buf_nxt[DW-1-8*int'(body_cnt) -: 8] = bus.byte_in;
          if (body_cnt == msg_len - 6'd1) begin
            msg_valid_nxt = 1'b1;
            msg_data_nxt  = data_buf_nxt;
            msg_len_q_nxt = msg_len;
            msg_idx_nxt   = msg_count;
            msg_count_nxt = msg_count + 2'd1;
            state_nxt     = NEXT;
          end else begin
            body_cnt_nxt = body_cnt + 6'd1;
          end
        end
        NEXT: begin
          if (bus.byte_in == ETX) begin
            pkt_done_nxt = 1'b1;
            msg_cnt_nxt  = msg_count;
            state_nxt    = IDLE;
          end else if (msg_count < 2'(MAX_MSGS)) begin
            data_buf_nxt = '0;
            len_acc_nxt  = 7'd0;
            len_step     = 1'b1;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase

      if (len_step) begin
        if (bus.byte_in[7]) begin
          if (len_ok) begin
            msg_len_nxt  = len_full[5:0];
            body_cnt_nxt = 6'd0;
            len_seen_nxt = 1'b0;
            state_nxt    = BODY;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = IDLE;
          end
        end else if (first_len) begin
          len_acc_nxt  = bus.byte_in[6:0];
          len_seen_nxt = 1'b1;
          state_nxt    = LEN;
        end else begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end
      end
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      len_seen    <= 1'b0;
      len_acc     <= 7'd0;
      body_cnt    <= 6'd0;
      msg_len     <= 6'd0;
      msg_count   <= 2'd0;
      data_buf    <= '0;
      msg_valid_q <= 1'b0;
      msg_data_q  <= '0;
      msg_len_q   <= 6'd0;
      msg_idx_q   <= 2'd0;
      pkt_done_q  <= 1'b0;
      msg_cnt_q   <= 2'd0;
      err_q       <= 1'b0;
    end else begin
      state       <= state_nxt;
      len_seen    <= len_seen_nxt;
      len_acc     <= len_acc_nxt;
      body_cnt    <= body_cnt_nxt;
      msg_len     <= msg_len_nxt;
      msg_count   <= msg_count_nxt;
      data_buf    <= data_buf_nxt;
      msg_valid_q <= msg_valid_nxt;
      msg_data_q  <= msg_data_nxt;
      msg_len_q   <= msg_len_q_nxt;
      msg_idx_q   <= msg_idx_nxt;
      pkt_done_q  <= pkt_done_nxt;
      msg_cnt_q   <= msg_cnt_nxt;
      err_q       <= err_nxt;
    end
  end
endmodule

// File: tb/tb_fast_packet_decode_module.sv
// Directed testbench for fast_packet_decode_module with an expected-event scoreboard.
module tb_fast_packet_decode_module;
  localparam int W = 264;

  logic clk;
  logic rst_n;

  fast_packet_decode_module_if #(.MAX_ORIGINAL_DATA_BITS(W)) bus ();

  fast_packet_decode_module #(.MAX_ORIGINAL_DATA_BITS(W), .MAX_MSGS(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    int           kind;
    logic [W-1:0] data;
    logic [5:0]   len;
    logic [1:0]   idx;
    logic [1:0]   cnt;
  } exp_t;

  exp_t sb[$];
  int   checks_total  = 0;
  int   checks_passed = 0;

  // Free-running clock, 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks_total++;
    assert (obs === exp) begin
      checks_passed++;
    end else begin
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b, input int gap = 0);
    bus.byte_in       = b;
    bus.byte_valid_in = 1'b1;
    @(posedge clk);
    #1;
    bus.byte_valid_in = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expectMsg(input logic [W-1:0] d, input logic [5:0] len, input logic [1:0] idx);
    exp_t e;
    e.kind = 0; e.data = d; e.len = len; e.idx = idx; e.cnt = 2'd0;
    sb.push_back(e);
  endtask

  task automatic expectDone(input logic [1:0] cnt);
    exp_t e;
    e.kind = 1; e.data = '0; e.len = 6'd0; e.idx = 2'd0; e.cnt = cnt;
    sb.push_back(e);
  endtask

  task automatic expectErr();
    exp_t e;
    e.kind = 2; e.data = '0; e.len = 6'd0; e.idx = 2'd0; e.cnt = 2'd0;
    sb.push_back(e);
  endtask

  task automatic waitDrain(input string tag);
    int n;
    n = 0;
    idle(3);
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, W'(sb.size()), W'(0));
  endtask

  task automatic checkAllZero(input string tag);
    @(negedge clk);
    checkOutput({tag, "_valid"}, W'(bus.msg_valid_out), W'(0));
    checkOutput({tag, "_data"},  bus.msg_data_out,      W'(0));
    checkOutput({tag, "_len"},   W'(bus.msg_len_out),   W'(0));
    checkOutput({tag, "_idx"},   W'(bus.msg_idx_out),   W'(0));
    checkOutput({tag, "_done"},  W'(bus.pkt_done_out),  W'(0));
    checkOutput({tag, "_cnt"},   W'(bus.msg_cnt_out),   W'(0));
    checkOutput({tag, "_err"},   W'(bus.err_out),       W'(0));
  endtask

  // Output monitor: every pulse must be single, expected, and match the scoreboard head.
  always @(negedge clk) begin
    if (bus.msg_valid_out || bus.pkt_done_out || bus.err_out) begin
      int   obs_kind;
      exp_t e;
      obs_kind = bus.msg_valid_out ? 0 : (bus.pkt_done_out ? 1 : 2);
      checkOutput("one_pulse", W'($countones({bus.msg_valid_out, bus.pkt_done_out, bus.err_out})), W'(1));
      if (sb.size() == 0) begin
        checkOutput("unexpected_pulse", W'(obs_kind), W'(3));
      end else begin
        e = sb.pop_front();
        checkOutput("kind", W'(obs_kind), W'(e.kind));
        if (e.kind == 0) begin
          checkOutput("msg_data", bus.msg_data_out,      e.data);
          checkOutput("msg_len",  W'(bus.msg_len_out),   W'(e.len));
          checkOutput("msg_idx",  W'(bus.msg_idx_out),   W'(e.idx));
        end else if (e.kind == 1) begin
          checkOutput("msg_cnt",  W'(bus.msg_cnt_out),   W'(e.cnt));
        end
      end
    end
  end

  initial begin
    bus.byte_in       = 8'h00;
    bus.byte_valid_in = 1'b0;
    rst_n             = 1'b0;
    idle(3);
    checkAllZero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    $display("[TB] single three-byte message");
    expectMsg({24'h414E4E, 240'h0}, 6'd3, 2'd0);
    expectDone(2'd1);
    applyStimulus(8'h02); applyStimulus(8'h83); applyStimulus(8'h41);
    applyStimulus(8'h4E); applyStimulus(8'h4E); applyStimulus(8'h03);
    waitDrain("drain_basic");
    checkOutput("hold_len",  W'(bus.msg_len_out), W'(3));
    checkOutput("hold_data", bus.msg_data_out, {24'h414E4E, 240'h0});

    $display("[TB] maximum length with two-byte length field");
    expectMsg({33{8'h55}}, 6'd33, 2'd0);
    expectDone(2'd1);
    applyStimulus(8'h02); applyStimulus(8'h00); applyStimulus(8'hA1);
    for (int i = 0; i < 33; i++) applyStimulus(8'h55);
    applyStimulus(8'h03);
    waitDrain("drain_max");

    $display("[TB] length 34 rejected, then recovery");
    expectErr();
    applyStimulus(8'h02); applyStimulus(8'h00); applyStimulus(8'hA2);
    waitDrain("drain_len34");
    expectMsg({8'h7E, 256'h0}, 6'd1, 2'd0);
    expectDone(2'd1);
    applyStimulus(8'h02); applyStimulus(8'h81); applyStimulus(8'h7E); applyStimulus(8'h03);
    waitDrain("drain_recover");

    $display("[TB] too many messages");
    expectMsg({8'h41, 256'h0}, 6'd1, 2'd0);
    expectMsg({8'h42, 256'h0}, 6'd1, 2'd1);
    expectMsg({8'h43, 256'h0}, 6'd1, 2'd2);
    expectErr();
    applyStimulus(8'h02);
    applyStimulus(8'h81); applyStimulus(8'h41);
    applyStimulus(8'h81); applyStimulus(8'h42);
    applyStimulus(8'h81); applyStimulus(8'h43);
    applyStimulus(8'h81);
    waitDrain("drain_overflow");

    $display("[TB] framing bytes as body data with idle gaps");
    expectMsg({24'h030203, 240'h0}, 6'd3, 2'd0);
    expectDone(2'd1);
    applyStimulus(8'h02, 2); applyStimulus(8'h83, 2); applyStimulus(8'h03, 2);
    applyStimulus(8'h02, 2); applyStimulus(8'h03, 2); applyStimulus(8'h03, 2);
    waitDrain("drain_gaps");

    $display("[TB] idle garbage, heartbeat, two messages");
    applyStimulus(8'h55); applyStimulus(8'h03); applyStimulus(8'hAA);
    expectDone(2'd0);
    applyStimulus(8'h02); applyStimulus(8'h03);
    waitDrain("drain_heartbeat");
    expectMsg({16'h0102, 248'h0}, 6'd2, 2'd0);
    expectMsg({8'hFF, 256'h0}, 6'd1, 2'd1);
    expectDone(2'd2);
    applyStimulus(8'h02); applyStimulus(8'h82); applyStimulus(8'h01); applyStimulus(8'h02);
    applyStimulus(8'h81); applyStimulus(8'hFF); applyStimulus(8'h03);
    waitDrain("drain_two");

    $display("[TB] zero length and oversized length errors");
    expectErr();
    applyStimulus(8'h02); applyStimulus(8'h80);
    waitDrain("drain_zero");
    expectErr();
    applyStimulus(8'h02); applyStimulus(8'h01); applyStimulus(8'h80);
    waitDrain("drain_big");
    expectErr();
    applyStimulus(8'h02); applyStimulus(8'h00); applyStimulus(8'h01);
    waitDrain("drain_nostop");

    $display("[TB] reset mid-packet");
    applyStimulus(8'h02); applyStimulus(8'h82); applyStimulus(8'h41);
    rst_n = 1'b0;
    idle(2);
    checkAllZero("midreset");
    rst_n = 1'b1;
    idle(1);
    applyStimulus(8'h42);
    expectMsg({8'h5A, 256'h0}, 6'd1, 2'd0);
    expectDone(2'd1);
    applyStimulus(8'h02); applyStimulus(8'h81); applyStimulus(8'h5A); applyStimulus(8'h03);
    waitDrain("drain_after_reset");

    $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end
endmodule
